// File: rtl/pe_stream_feeder_if.sv
// Bundle of the load, PE-drive and result signals around one pe_stream_feeder.
// master: the feeder itself; slave: loader, PE and result collector side.
interface pe_stream_feeder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             ld_valid;
  logic             ld_ready;
  logic [WIDTH-1:0] ld_a;
  logic [WIDTH-1:0] ld_b;
  logic             pe_en;
  logic [WIDTH-1:0] pe_a;
  logic [WIDTH-1:0] pe_b;
  logic [WIDTH-1:0] pe_p;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             busy;

  modport master (
    input  ld_valid, ld_a, ld_b, pe_p, res_ready,
    output ld_ready, pe_en, pe_a, pe_b, res_valid, res_data, busy
  );

  modport slave (
    output ld_valid, ld_a, ld_b, pe_p, res_ready,
    input  ld_ready, pe_en, pe_a, pe_b, res_valid, res_data, busy
  );
endinterface

// File: rtl/pe_stream_feeder.sv
// Buffers one DIMENSION-long operand-pair batch, streams it into a MAC PE with
// pe_en high for exactly DIMENSION cycles, captures the PE sum one cycle after
// the burst and offers it on a valid/ready result port.
module pe_stream_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIMENSION = 16,
  parameter int unsigned AW        = 5
) (
  input  logic              clk,
  input  logic              rst,
  pe_stream_feeder_if.master bus
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2,
    OUT     = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_idx_q, wr_idx_d;
  logic [AW-1:0]    rd_idx_q, rd_idx_d;
  logic             ld_ready_q, ld_ready_d;
  logic             pe_en_q, pe_en_d;
  logic [WIDTH-1:0] pe_a_q, pe_a_d;
  logic [WIDTH-1:0] pe_b_q, pe_b_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] buf_a_q [DEPTH];
  logic [WIDTH-1:0] buf_b_q [DEPTH];

  logic ld_fire_c;
  assign ld_fire_c = bus.ld_valid && ld_ready_q;

  // Operand buffer write; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (ld_fire_c) begin
      buf_a_q[wr_idx_q] <= bus.ld_a;
      buf_b_q[wr_idx_q] <= bus.ld_b;
    end
  end

  // State, index and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LOAD;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      ld_ready_q  <= 1'b0;
      pe_en_q     <= 1'b0;
      pe_a_q      <= '0;
      pe_b_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      ld_ready_q  <= ld_ready_d;
      pe_en_q     <= pe_en_d;
      pe_a_q      <= pe_a_d;
      pe_b_q      <= pe_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic; outputs follow the upcoming state so
  // the registered values line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    res_data_d  = res_data_q;
    ld_ready_d  = 1'b0;
    pe_en_d     = 1'b0;
    pe_a_d      = '0;
    pe_b_d      = '0;
    res_valid_d = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      LOAD: begin
        if (ld_fire_c) begin
          if (wr_idx_q == AW'(DIMENSION - 1)) begin
            wr_idx_d = '0;
            state_d  = RUN;
          end else begin
            wr_idx_d = wr_idx_q + AW'(1);
          end
        end
      end
      RUN: begin
        // rd_idx_q counts elements already presented to the PE.
        if (rd_idx_q == AW'(DIMENSION)) begin
          rd_idx_d = '0;
          state_d  = CAPTURE;
        end
      end
      CAPTURE: begin
        // PE holds its full sum only during this en-low cycle.
        res_data_d = bus.pe_p;
        state_d    = OUT;
      end
      OUT: begin
        if (res_valid_q && bus.res_ready) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase

    // The element stream starts on the edge of the last load handshake.
    if (state_d == RUN) begin
      pe_en_d  = 1'b1;
      pe_a_d   = buf_a_q[rd_idx_q];
      pe_b_d   = buf_b_q[rd_idx_q];
      rd_idx_d = rd_idx_q + AW'(1);
    end

    ld_ready_d  = (state_d == LOAD);
    res_valid_d = (state_d == OUT);
    busy_d      = (state_d != LOAD);
  end

  assign bus.ld_ready  = ld_ready_q;
  assign bus.pe_en     = pe_en_q;
  assign bus.pe_a      = pe_a_q;
  assign bus.pe_b      = pe_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_pe_stream_feeder.sv
// Bench for pe_stream_feeder with a behavioural MAC PE attached; expected
// results and element streams are queued at stimulus time and checked by
// independent monitors.
module tb_pe_stream_feeder;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned DIMENSION = 16;
  localparam int unsigned AW        = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  pe_stream_feeder_if #(.WIDTH(WIDTH)) bus ();

  pe_stream_feeder #(
    .WIDTH(WIDTH),
    .DIMENSION(DIMENSION),
    .AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  // Behavioural PE: accumulates while en is high, clears on any en-low edge.
  logic [WIDTH-1:0] pe_p_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           pe_p_q <= '0;
    else if (bus.pe_en) pe_p_q <= WIDTH'(pe_p_q + bus.pe_a * bus.pe_b);
    else                pe_p_q <= '0;
  end
  assign bus.pe_p = pe_p_q;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0]      elem_q [$];
  logic [WIDTH-1:0] exp_q  [$];
  logic [WIDTH-1:0] va [DIMENSION];
  logic [WIDTH-1:0] vb [DIMENSION];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: PE element stream, burst length and result handshakes.
  initial begin
    int run_len;
    logic [15:0] e;
    logic [WIDTH-1:0] r;
    run_len = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        run_len = 0;
      end else begin
        if (bus.pe_en) begin
          if (elem_q.size() == 0) begin
            fail_now("pe_elem_unexpected");
          end else begin
            e = elem_q.pop_front();
            check("pe_a", 32'(bus.pe_a), 32'(e[15:8]));
            check("pe_b", 32'(bus.pe_b), 32'(e[7:0]));
          end
          run_len++;
        end else if (run_len != 0) begin
          check("burst_len", 32'(run_len), 32'(DIMENSION));
          check("pe_ab_idle", {16'd0, bus.pe_a, bus.pe_b}, 32'd0);
          run_len = 0;
        end
        if (bus.res_valid && bus.res_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("res_unexpected");
          end else begin
            r = exp_q.pop_front();
            check("res_data", 32'(bus.res_data), 32'(r));
          end
        end
      end
    end
  end

  task automatic fill_const(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    for (int k = 0; k < int'(DIMENSION); k++) begin
      va[k] = a;
      vb[k] = b;
    end
  endtask

  // Offers the va/vb batch; returns at posedge+1 of the first pe_en cycle.
  task automatic load_batch(input bit stall, input logic [WIDTH-1:0] exp);
    int i;
    int g;
    logic hs;
    for (int k = 0; k < int'(DIMENSION); k++) elem_q.push_back({va[k], vb[k]});
    exp_q.push_back(exp);
    i = 0;
    g = 0;
    while (i < int'(DIMENSION) && g < 400) begin
      bus.ld_valid = stall ? logic'(g % 2 == 0) : 1'b1;
      bus.ld_a     = bus.ld_valid ? va[i] : 8'hEE;
      bus.ld_b     = bus.ld_valid ? vb[i] : 8'hEE;
      @(negedge clk);
      hs = bus.ld_valid && bus.ld_ready;
      @(posedge clk);
      #1;
      if (hs) i++;
      g++;
    end
    bus.ld_valid = 1'b0;
    bus.ld_a     = '0;
    bus.ld_b     = '0;
    if (i < int'(DIMENSION)) begin
      fail_now("load_timeout");
    end else begin
      check("ld_ready_after_load", 32'(bus.ld_ready), 32'd0);
      check("pe_en_first", 32'(bus.pe_en), 32'd1);
    end
  endtask

  // Waits for res_valid, optionally stalls the result hold cycles, completes
  // the handshake and checks the return to LOAD.
  task automatic wait_result(input int hold, input int exp_lat, input logic [WIDTH-1:0] exp);
    int n;
    n = 1;
    bus.res_ready = (hold == 0);
    @(negedge clk);
    while (!bus.res_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      @(negedge clk);
    end
    if (!bus.res_valid) begin
      fail_now("res_timeout");
    end else begin
      if (exp_lat != 0) check("latency", 32'(n), 32'(exp_lat));
      if (hold > 0) begin
        bus.ld_valid = 1'b1;
        bus.ld_a     = 8'hFF;
        bus.ld_b     = 8'hFF;
        for (int k = 0; k < hold; k++) begin
          if (k > 0) @(negedge clk);
          check("hold_valid", 32'(bus.res_valid), 32'd1);
          check("hold_data", 32'(bus.res_data), 32'(exp));
          check("hold_ld_ready", 32'(bus.ld_ready), 32'd0);
          check("hold_pe_en", 32'(bus.pe_en), 32'd0);
          check("hold_busy", 32'(bus.busy), 32'd1);
          @(posedge clk);
          #1;
        end
        bus.ld_valid  = 1'b0;
        bus.ld_a      = '0;
        bus.ld_b      = '0;
        bus.res_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      check("res_valid_drop", 32'(bus.res_valid), 32'd0);
      check("ld_ready_return", 32'(bus.ld_ready), 32'd1);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ld_valid  = 1'b0;
    bus.ld_a      = '0;
    bus.ld_b      = '0;
    bus.res_ready = 1'b1;
    rst = 1'b0;
    #12;
    check("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("rst_pe_en", 32'(bus.pe_en), 32'd0);
    check("rst_pe_a", 32'(bus.pe_a), 32'd0);
    check("rst_pe_b", 32'(bus.pe_b), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("ld_ready_pre_rise", 32'(bus.ld_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ld_ready_rise", 32'(bus.ld_ready), 32'd1);

    // Basic sum: A=1, B=1..16 -> 136, result in cycle 18 after last load.
    for (int k = 0; k < int'(DIMENSION); k++) begin
      va[k] = 8'd1;
      vb[k] = 8'(k + 1);
    end
    load_batch(1'b0, 8'd136);
    wait_result(0, 18, 8'd136);

    // Wrap: 16*30 = 480 -> 224.
    fill_const(8'd3, 8'd10);
    load_batch(1'b0, 8'd224);
    wait_result(0, 18, 8'd224);

    // Load stalls: A=k, B=k+1 -> sum k(k+1) = 1360 -> 80.
    for (int k = 0; k < int'(DIMENSION); k++) begin
      va[k] = 8'(k);
      vb[k] = 8'(k + 1);
    end
    load_batch(1'b1, 8'd80);
    wait_result(0, 18, 8'd80);

    // Result backpressure: 16*6 = 96, held 10 cycles with junk offered.
    fill_const(8'd2, 8'd3);
    load_batch(1'b0, 8'd96);
    wait_result(10, 18, 8'd96);

    // Back-to-back batches: 64 then 80.
    fill_const(8'd2, 8'd2);
    load_batch(1'b0, 8'd64);
    wait_result(0, 0, 8'd64);
    fill_const(8'd1, 8'd5);
    load_batch(1'b0, 8'd80);
    wait_result(0, 0, 8'd80);

    // Mid-run reset at the 7th pe_en cycle; partial batch is discarded.
    fill_const(8'd5, 8'd5);
    load_batch(1'b0, 8'd144);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    check("pe_en_before_reset", 32'(bus.pe_en), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_pe_en", 32'(bus.pe_en), 32'd0);
    check("async_res_valid", 32'(bus.res_valid), 32'd0);
    check("async_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("async_busy", 32'(bus.busy), 32'd0);
    elem_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ld_ready_after_reset", 32'(bus.ld_ready), 32'd1);
    fill_const(8'd1, 8'd1);
    load_batch(1'b0, 8'd16);
    wait_result(0, 18, 8'd16);

    repeat (3) @(posedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("elem_q_drained", 32'(elem_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
